// File: rtl/multdiv_sequencer_pkg.sv
// Shared constants, state encoding and ALU-op codes for the multi-cycle multiply/divide unit
// and the decode-stage stall logic that drives it.
package multdiv_sequencer_pkg;

    localparam int unsigned DataWidth = 32;
    localparam int unsigned NumIters  = 32;
    localparam int unsigned CntWidth  = 6;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StMul  = 2'b01,
        StDiv  = 2'b10,
        StDone = 2'b11
    } state_e;

    // R-type ALU-op codes that the decode stage turns into start pulses
    localparam logic [4:0] AluOpMult = 5'b00110;
    localparam logic [4:0] AluOpDiv  = 5'b00111;

endpackage

// File: rtl/multdiv_sequencer_iter_counter.sv
// Iteration counter: cleared on a start edge, counts while an operation runs and flags the edge
// on which the count reaches ITERS.
module multdiv_sequencer_iter_counter
    import multdiv_sequencer_pkg::*;
#(
    parameter int unsigned ITERS = NumIters
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic term
);

    logic [CntWidth-1:0] count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + 1'b1;
        end
    end

    // High during the last iteration, so the edge that follows brings count to ITERS
    assign term = enable && (count_q == CntWidth'(ITERS - 1));

endmodule

// File: rtl/multdiv_sequencer.sv
// Multi-cycle signed multiply (radix-2 Booth) and divide (restoring, on magnitudes) unit.
// One start pulse, 32 iterations, then a one-cycle data_resultRDY that releases the stall.
module multdiv_sequencer
    import multdiv_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = DataWidth,
    parameter int unsigned ITERS = NumIters
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH - 1){1'b0}}};

    state_e state_q, state_d;

    logic start, running, term;

    // Working registers: hi/lo form the Booth accumulator or the remainder/quotient pair
    logic [WIDTH:0]   hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] m_q;
    logic             qm1_q;
    logic             neg_q, dz_q, ovf_q;

    logic [WIDTH-1:0] result_q;
    logic             exc_q;

    assign start   = ((state_q == StIdle) || (state_q == StDone)) && (ctrl_MULT || ctrl_DIV);
    assign running = (state_q == StMul) || (state_q == StDiv);

    multdiv_sequencer_iter_counter #(
        .ITERS (ITERS)
    ) u_iter_counter (
        .clock  (clock),
        .reset  (reset),
        .clear  (start),
        .enable (running),
        .term   (term)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = ctrl_MULT ? StMul : StDiv;
            end
            StMul, StDiv: begin
                if (term) state_d = StDone;
            end
            StDone: begin
                state_d = start ? (ctrl_MULT ? StMul : StDiv) : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Booth step: inspect {lo[0], q-1}, add/subtract multiplicand, arithmetic shift right
    logic [WIDTH:0]   m_ext, booth_sum, mul_hi_n;
    logic [WIDTH-1:0] mul_lo_n;
    logic [WIDTH:0]   product_hi;
    logic             mul_exc;

    always_comb begin
        m_ext = {m_q[WIDTH-1], m_q};
        unique case ({lo_q[0], qm1_q})
            2'b01:   booth_sum = hi_q + m_ext;
            2'b10:   booth_sum = hi_q - m_ext;
            default: booth_sum = hi_q;
        endcase
        mul_hi_n   = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        mul_lo_n   = {booth_sum[0], lo_q[WIDTH-1:1]};
        product_hi = {mul_hi_n[WIDTH-1:0], mul_lo_n[WIDTH-1]};
        mul_exc    = !((&product_hi) || (~|product_hi));
    end

    // Restoring division step on magnitudes; the wide difference exposes the borrow
    logic [WIDTH:0]   div_shift, div_hi_n;
    logic [WIDTH+1:0] div_diff;
    logic             div_ok;
    logic [WIDTH-1:0] div_lo_n, quot;

    always_comb begin
        div_shift = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, m_q};
        div_ok    = !div_diff[WIDTH+1];
        div_hi_n  = div_ok ? div_diff[WIDTH:0] : div_shift;
        div_lo_n  = {lo_q[WIDTH-2:0], div_ok};
        quot      = neg_q ? (~div_lo_n + 1'b1) : div_lo_n;
    end

    logic [WIDTH-1:0] abs_a, abs_b;
    assign abs_a = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
    assign abs_b = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            hi_q     <= '0;
            lo_q     <= '0;
            m_q      <= '0;
            qm1_q    <= 1'b0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start) begin
                hi_q  <= '0;
                qm1_q <= 1'b0;
                lo_q  <= ctrl_MULT ? data_operandB : abs_a;
                m_q   <= ctrl_MULT ? data_operandA : abs_b;
                neg_q <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                dz_q  <= (data_operandB == '0);
                ovf_q <= (data_operandA == MinVal) && (&data_operandB);
            end else if (state_q == StMul) begin
                hi_q  <= mul_hi_n;
                lo_q  <= mul_lo_n;
                qm1_q <= lo_q[0];
                if (term) begin
                    result_q <= mul_lo_n;
                    exc_q    <= mul_exc;
                end
            end else if (state_q == StDiv) begin
                hi_q <= div_hi_n;
                lo_q <= div_lo_n;
                if (term) begin
                    result_q <= dz_q ? '0 : quot;
                    exc_q    <= dz_q || ovf_q;
                end
            end
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == StDone);
    assign busy           = running;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer: an arithmetic reference model checked every cycle,
// plus literal expectations per operation.
module tb_multdiv_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    multdiv_sequencer dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the signed-integer definitions
    function automatic void ref_op(input logic is_mul, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic e);
        longint p;
        int     as, bs;
        if (is_mul) begin
            p = longint'($signed(a)) * longint'($signed(b));
            r = p[31:0];
            e = (p != longint'($signed(r)));
        end else if (b == 32'h0) begin
            r = 32'h0;
            e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000;
            e = 1'b1;
        end else begin
            as = $signed(a);
            bs = $signed(b);
            r  = 32'(as / bs);
            e  = 1'b0;
        end
    endfunction

    // Model: an accepted start yields a ready pulse 32 edges later with the reference result
    int          m_cnt = 0;
    logic        m_rdy = 1'b0;
    logic [31:0] m_res = '0;
    logic        m_exc = 1'b0;
    logic [31:0] pend_res = '0;
    logic        pend_exc = 1'b0;

    initial forever begin
        @(posedge clock or posedge reset);
        if (reset) begin
            m_cnt = 0;
            m_rdy = 1'b0;
            m_res = '0;
            m_exc = 1'b0;
        end else if (m_cnt > 0) begin
            m_cnt--;
            m_rdy = (m_cnt == 0);
            if (m_cnt == 0) begin
                m_res = pend_res;
                m_exc = pend_exc;
            end
        end else begin
            m_rdy = 1'b0;
            if (ctrl_MULT || ctrl_DIV) begin
                m_cnt = 32;
                ref_op(ctrl_MULT, data_operandA, data_operandB, pend_res, pend_exc);
            end
        end
    end

    initial forever begin
        @(negedge clock);
        if (chk_en) begin
            check("cyc_rdy", 32'(data_resultRDY), 32'(m_rdy));
            check("cyc_busy", 32'(busy), 32'(m_cnt > 0));
            check("cyc_result", data_result, m_res);
            check("cyc_exc", 32'(data_exception), 32'(m_exc));
        end
    end

    // Issue a start at the current negedge and wait (bounded) for the ready pulse
    task automatic run_op(input string name, input logic mul, input logic div,
                          input logic [31:0] a, input logic [31:0] b, input int inj_div_at,
                          input logic [31:0] exp_res, input logic exp_exc);
        int lat = 0;
        int busy_cycles = 0;
        ctrl_MULT     = mul;
        ctrl_DIV      = div;
        data_operandA = a;
        data_operandB = b;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            lat = k;
            if (k == 1) begin
                ctrl_MULT     = 1'b0;
                ctrl_DIV      = 1'b0;
                data_operandA = $urandom;
                data_operandB = $urandom;
            end
            if (k == inj_div_at) ctrl_DIV = 1'b1;
            if (k == inj_div_at + 1) ctrl_DIV = 1'b0;
            if (data_resultRDY) break;
            if (busy) busy_cycles++;
        end
        ctrl_DIV = 1'b0;
        check({name, "_latency"}, 32'(lat), 32'd33);
        check({name, "_busy_cycles"}, 32'(busy_cycles), 32'd32);
        check({name, "_result"}, data_result, exp_res);
        check({name, "_exc"}, 32'(data_exception), 32'(exp_exc));
    endtask

    initial begin
        int rdy_seen;
        repeat (3) @(negedge clock);
        check("reset_rdy", 32'(data_resultRDY), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_result", data_result, 32'd0);
        check("reset_exc", 32'(data_exception), 32'd0);
        reset  = 1'b0;
        chk_en = 1'b1;
        @(negedge clock);

        run_op("mul_7_m3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 0, 32'hFFFF_FFEB, 1'b0);
        repeat (2) @(negedge clock);
        run_op("mul_ovf", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 0, 32'h0, 1'b1);
        @(negedge clock);
        run_op("mul_min_1", 1'b1, 1'b0, 32'h8000_0000, 32'd1, 0, 32'h8000_0000, 1'b0);
        @(negedge clock);
        run_op("div_m7_2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFD, 1'b0);
        @(negedge clock);
        run_op("div_100_7", 1'b0, 1'b1, 32'd100, 32'd7, 0, 32'd14, 1'b0);
        @(negedge clock);
        run_op("div_by_zero", 1'b0, 1'b1, 32'd5, 32'd0, 0, 32'd0, 1'b1);
        @(negedge clock);
        run_op("div_min_m1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, 1'b1);
        @(negedge clock);

        // Abort a multiply with an asynchronous reset part-way through
        ctrl_MULT     = 1'b1;
        data_operandA = 32'h0000_1234;
        data_operandB = 32'h0000_5678;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        repeat (10) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("abort_rdy", 32'(data_resultRDY), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_result", data_result, 32'd0);
        check("abort_exc", 32'(data_exception), 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset    = 1'b0;
        rdy_seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (data_resultRDY) rdy_seen++;
        end
        check("abort_no_rdy", 32'(rdy_seen), 32'd0);
        run_op("div_9_3", 1'b0, 1'b1, 32'd9, 32'd3, 0, 32'd3, 1'b0);
        @(negedge clock);

        // Stray divide pulse mid-multiply, then a back-to-back start in the ready cycle
        run_op("mul_ignore_div", 1'b1, 1'b0, 32'h0000_1234, 32'h0000_0010, 6, 32'h0001_2340,
               1'b0);
        run_op("mul_back2back", 1'b1, 1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 0, 32'd30, 1'b0);
        @(negedge clock);
        run_op("both_pulses", 1'b1, 1'b1, 32'd6, 32'd3, 0, 32'd18, 1'b0);
        repeat (3) @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multdiv_sequencer.md
Name: multdiv_sequencer

Overview:
- Multi-cycle signed multiply/divide unit on the execute side of the 5-stage pipeline.
- It is the responder to the decode-stage stall logic:
  - It accepts a one-cycle start pulse for MULT or DIV.
  - It iterates for a fixed 32 cycles.
  - It returns a one-cycle data_resultRDY pulse, which releases the pipeline stall.
- Datapath: radix-2 Booth multiply; restoring division on operand magnitudes.

Parameters:
- WIDTH, 32, operand/result width.
- ITERS, 32, iterations per operation; must equal WIDTH.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- ctrl_MULT  in  1  one-cycle start pulse for signed multiply.
- ctrl_DIV  in  1  one-cycle start pulse for signed divide.
- data_operandA  in  WIDTH  multiplicand / dividend; sampled only on the start edge.
- data_operandB  in  WIDTH  multiplier / divisor; sampled only on the start edge.
- data_result  out  WIDTH  low product or quotient; held until the next start.
- data_exception  out  1  overflow or divide-by-zero flag; valid with data_result.
- data_resultRDY  out  1  one-cycle completion pulse.
- busy  out  1  high from the start edge until the cycle data_resultRDY is high, exclusive of that cycle.

Behaviour:
- Reset values: state=IDLE, count=0, data_result=0, data_exception=0, data_resultRDY=0, busy=0.
  - Reset mid-operation aborts the operation; no data_resultRDY is produced.
- States: IDLE, MUL, DIV, DONE.
- Start edge E0 (state IDLE or DONE, start pulse sampled high):
  - Latch both operands and the operation type; count=0.
  - Next state is MUL or DIV.
- Priority: ctrl_MULT and ctrl_DIV high together → MUL wins.
- Start pulses sampled in MUL or DIV are ignored. No queueing; data_operandA/B changes are also ignored.
- Edges E1..E32: one iteration per edge; count increments.
  - At E32 (count reaches ITERS) state→DONE, and data_result/data_exception are registered.
- DONE cycle (after E32): data_resultRDY=1 and busy=0.
  - Next edge → IDLE, or → MUL/DIV if a start pulse is sampled (back-to-back start).
- Latency: data_resultRDY is visible after the 32nd edge following the start edge. It is high for exactly one cycle.
  - Divide-by-zero also takes the full 32 iterations, so latency is uniform.
- Multiply:
  - Signed 32x32 → 64-bit Booth product.
  - data_result = product[31:0].
  - data_exception=1 iff product[63:31] is not all-equal (result does not fit in signed 32 bits).
- Divide:
  - Form |A| and |B|; run 32-step unsigned restoring division.
  - Quotient sign = A[31] xor B[31]; truncate toward zero; remainder discarded.
  - B=0 → data_result=0, data_exception=1.
  - A=0x80000000, B=0xFFFFFFFF → data_result=0x80000000, data_exception=1.
- data_result and data_exception hold their values through IDLE until the next DONE. They clear only on reset.
- Edge case to handle: the decode-stage stall flop is cleared by data_resultRDY. If data_resultRDY rises in the same cycle a new start is sampled, the new operation must still complete normally.

Decomposition:
- Shared package:
  - WIDTH/ITERS constants.
  - State encoding (IDLE=2'b00, MUL=2'b01, DIV=2'b10, DONE=2'b11).
  - R-type ALU-op codes MULT=5'b00110 and DIV=5'b00111, shared with the decode stall logic.
- One natural sub-module: iter_counter.
  - A 6-bit up-counter with synchronous clear on start and a terminal-count output at ITERS.
  - Async active-high reset.
- The Booth and divider step logic stays in the top module.

Test Plan:
- MULT A=7, B=0xFFFFFFFD (-3) → data_resultRDY single pulse after the 32nd edge post-start; data_result=0xFFFFFFEB; data_exception=0; busy high for exactly 32 cycles.
- MULT A=0x00010000, B=0x00010000 → data_result=0x00000000, data_exception=1. Then MULT 0x80000000 × 1 → data_result=0x80000000, data_exception=0.
- DIV A=0xFFFFFFF9 (-7), B=2 → data_result=0xFFFFFFFD (-3), data_exception=0. Then DIV 100/7 → data_result=14.
- DIV A=5, B=0 → data_resultRDY after 32 edges; data_result=0, data_exception=1. DIV 0x80000000/0xFFFFFFFF → data_result=0x80000000, data_exception=1.
- Assert reset async mid-MUL at iteration 10 → all outputs 0 immediately; no data_resultRDY; a fresh DIV 9/3 afterwards → data_result=3.
- Pulse ctrl_DIV at iteration 5 of a MULT (ignored; MULT result correct). Then a ctrl_MULT pulse in the DONE cycle → second operation starts, with its data_resultRDY exactly 32 edges later. Simultaneous ctrl_MULT and ctrl_DIV with A=6, B=3 → data_result=18.
